// File: rtl/mole_pkg.sv
// Shared types and constants for the mole field controller.
package mole_pkg;

  typedef enum logic [1:0] {
    MOLE_ADD1 = 2'd0,
    MOLE_ADD2 = 2'd1,
    MOLE_RED2 = 2'd2
  } mole_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UP    = 2'd1,
    S_FLASH = 2'd2
  } slot_state_e;

  localparam logic [1:0]  GAME_PLAYING = 2'b01;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // Width of the per-slot tick counters; must cover GAP_TICKS + 15 and the other loads.
  localparam int unsigned CNT_W = 16;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Slot i scores as type i % 3.
  function automatic mole_type_e slot_type(input int unsigned idx);
    mole_type_e t;
    case (idx % 3)
      0:       t = MOLE_ADD1;
      1:       t = MOLE_ADD2;
      default: t = MOLE_RED2;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole slot: IDLE -> UP -> (hit) FLASH -> IDLE, with a tick-driven counter.
// A counter "reaches 0" on the tick where it is 1 (or already 0), so a load of N
// lasts exactly N ticks.
module mole_slot import mole_pkg::*; #(
  parameter int unsigned SLOT_IDX    = 0,
  parameter int unsigned UP_TICKS    = 100,
  parameter int unsigned FLASH_TICKS = 25,
  parameter int unsigned GAP_TICKS   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        playing,
  input  logic        tick,
  input  logic        hit,
  input  logic        spawn_ok,
  input  logic [3:0]  spawn_loc,
  input  logic [3:0]  gap_seed,
  output slot_state_e state,
  output logic [3:0]  location,
  output logic        ready
);

  localparam logic [CNT_W-1:0] RST_GAP    = CNT_W'(GAP_TICKS + SLOT_IDX);
  localparam logic [CNT_W-1:0] UP_LOAD    = CNT_W'(UP_TICKS);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TICKS);

  slot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       loc_q, loc_d;
  logic             expire;

  assign expire   = (cnt_q <= CNT_W'(1));
  assign ready    = (state_q == S_IDLE) && expire;
  assign state    = state_q;
  assign location = loc_q;

  // Next-state: stop forces idle, a hit beats a tick, otherwise tick-driven countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loc_d   = loc_q;
    if (!playing) begin
      state_d = S_IDLE;
      cnt_d   = RST_GAP;
    end else if (hit && (state_q == S_UP)) begin
      state_d = S_FLASH;
      cnt_d   = FLASH_LOAD;
    end else if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!expire) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (spawn_ok) begin
            state_d = S_UP;
            cnt_d   = UP_LOAD;
            loc_d   = spawn_loc;
          end else begin
            cnt_d = '0;  // blocked by a collision, retry next tick
          end
        end
        S_UP, S_FLASH: begin
          if (!expire) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = CNT_W'(GAP_TICKS) + CNT_W'(gap_seed);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = RST_GAP;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= RST_GAP;
      loc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loc_q   <= loc_d;
    end
  end

endmodule

// File: rtl/mole_field_ctrl.sv
// Mole field controller: NUM_SLOTS concurrent moles over NUM_HOLES holes.
// Optional build macro MOLE_MISS_PENALTY_EN adds a 'miss' pulse output for key
// presses that match no visible mole.
module mole_field_ctrl import mole_pkg::*; #(
  parameter int unsigned NUM_SLOTS   = 3,
  parameter int unsigned NUM_HOLES   = 16,
  parameter int unsigned TICK_DIV    = 1000000,
  parameter int unsigned UP_TICKS    = 100,
  parameter int unsigned FLASH_TICKS = 25,
  parameter int unsigned GAP_TICKS   = 20,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             game_state,
  input  logic                   key_valid,
  input  logic [3:0]             key_num,
  output logic                   add_1,
  output logic                   add_2,
  output logic                   reduce_2,
  output logic [NUM_SLOTS-1:0]   enable,
  output logic [NUM_SLOTS-1:0]   flag,
  output logic [4*NUM_SLOTS-1:0] location
`ifdef MOLE_MISS_PENALTY_EN
  ,
  output logic                   miss
`endif
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRESC_W-1:0] presc_q;
  logic               tick;
  logic [15:0]        lfsr_q;
  logic               playing;
  logic [3:0]         cand;

  slot_state_e        slot_state [NUM_SLOTS];
  logic [3:0]         slot_loc   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_ready, spawn_ok, hit, seen;

  assign playing = (game_state == GAME_PLAYING);
  assign tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign cand    = 4'(32'(lfsr_q[3:0]) % NUM_HOLES);

  // Game-tick prescaler, free running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PRESC_W'(1);
  end

  // Hole/gap randomiser, advances every clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_next(lfsr_q);
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    mole_slot #(
      .SLOT_IDX    (g),
      .UP_TICKS    (UP_TICKS),
      .FLASH_TICKS (FLASH_TICKS),
      .GAP_TICKS   (GAP_TICKS)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .playing   (playing),
      .tick      (tick),
      .hit       (hit[g]),
      .spawn_ok  (spawn_ok[g]),
      .spawn_loc (cand),
      .gap_seed  (lfsr_q[7:4]),
      .state     (slot_state[g]),
      .location  (slot_loc[g]),
      .ready     (slot_ready[g])
    );

    assign enable[g]         = (slot_state[g] != S_IDLE);
    assign flag[g]           = (slot_state[g] == S_FLASH);
    assign location[4*g +: 4] = slot_loc[g];
    assign hit[g]  = playing && key_valid && (slot_state[g] == S_UP) && (slot_loc[g] == key_num);
    assign seen[g] = key_valid && enable[g] && (slot_loc[g] == key_num);
  end

  // Collision check: all slots share one candidate, so the lowest ready slot
  // wins and only if no visible mole already sits on that hole.
  always_comb begin : p_spawn
    logic taken;
    logic clash;
    taken    = 1'b0;
    clash    = 1'b0;
    spawn_ok = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      clash = 1'b0;
      for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
        if (enable[j] && (slot_loc[j] == cand)) clash = 1'b1;
      end
      spawn_ok[i] = tick && slot_ready[i] && !clash && !taken;
      taken       = taken | spawn_ok[i];
    end
  end

  logic add_1_d, add_2_d, reduce_2_d;

  // Fold per-slot hits into the three score pulses by slot type.
  always_comb begin
    add_1_d    = 1'b0;
    add_2_d    = 1'b0;
    reduce_2_d = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      case (slot_type(i))
        MOLE_ADD1: add_1_d    = add_1_d    | hit[i];
        MOLE_ADD2: add_2_d    = add_2_d    | hit[i];
        default:   reduce_2_d = reduce_2_d | hit[i];
      endcase
    end
  end

  // Registered one-cycle score pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_1    <= 1'b0;
      add_2    <= 1'b0;
      reduce_2 <= 1'b0;
    end else begin
      add_1    <= add_1_d;
      add_2    <= add_2_d;
      reduce_2 <= reduce_2_d;
    end
  end

`ifdef MOLE_MISS_PENALTY_EN
  // Miss pulse for a key that lands on no visible mole.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) miss <= 1'b0;
    else      miss <= playing && key_valid && (seen == '0);
  end
`endif

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Self-checking bench for mole_field_ctrl with a per-cycle behavioural model.
module tb_mole_field_ctrl;

  localparam int NS   = 3;
  localparam int NH   = 6;
  localparam int TDIV = 4;
  localparam int UPT  = 5;
  localparam int FLT  = 3;
  localparam int GAPT = 2;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef MOLE_MISS_PENALTY_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] game_state = 2'b00;
  logic key_valid = 1'b0;
  logic [3:0] key_num = 4'd0;
  logic add_1, add_2, reduce_2;
  logic [NS-1:0] enable, flag;
  logic [4*NS-1:0] location;
  logic dut_miss;
  logic [21:0] dut_vec;

  mole_field_ctrl #(
    .NUM_SLOTS   (NS),
    .NUM_HOLES   (NH),
    .TICK_DIV    (TDIV),
    .UP_TICKS    (UPT),
    .FLASH_TICKS (FLT),
    .GAP_TICKS   (GAPT),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_state (game_state),
    .key_valid  (key_valid),
    .key_num    (key_num),
    .add_1      (add_1),
    .add_2      (add_2),
    .reduce_2   (reduce_2),
    .enable     (enable),
    .flag       (flag),
    .location   (location)
`ifdef MOLE_MISS_PENALTY_EN
    ,
    .miss       (dut_miss)
`endif
  );

`ifndef MOLE_MISS_PENALTY_EN
  assign dut_miss = 1'b0;
`endif
  assign dut_vec = {enable, flag, location, add_1, add_2, reduce_2, dut_miss};

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: mode 0 = empty, 1 = mole up, 2 = hit flash.
  int m_mode[NS];
  int m_cnt[NS];
  int m_loc[NS];
  int m_presc;
  logic [15:0] m_lfsr;
  bit m_a1, m_a2, m_r2, m_miss, m_tick;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_mode[i] = 0;
      m_cnt[i]  = GAPT + i;
      m_loc[i]  = 0;
    end
    m_presc = 0;
    m_lfsr  = SEED;
    m_a1 = 0; m_a2 = 0; m_r2 = 0; m_miss = 0; m_tick = 0;
  endtask

  function automatic logic [21:0] exp_vec();
    logic [NS-1:0] en, fl;
    logic [4*NS-1:0] loc;
    for (int i = 0; i < NS; i++) begin
      en[i] = (m_mode[i] != 0);
      fl[i] = (m_mode[i] == 2);
      loc[4*i +: 4] = 4'(m_loc[i]);
    end
    return {en, fl, loc, m_a1, m_a2, m_r2, m_miss};
  endfunction

  // Advance DUT and model by one clock; returns at the following falling edge.
  task automatic step();
    int nmode[NS], ncnt[NS], nloc[NS];
    int cand, gseed, hs;
    bit playing, any_vis, taken, clash;
    m_tick  = (m_presc == TDIV - 1);
    playing = (game_state == 2'b01);
    cand    = int'(m_lfsr[3:0]) % NH;
    gseed   = int'(m_lfsr[7:4]);
    nmode = m_mode; ncnt = m_cnt; nloc = m_loc;
    hs = -1; any_vis = 0; taken = 0;
    if (playing && key_valid) begin
      for (int i = 0; i < NS; i++) begin
        if (m_mode[i] != 0 && m_loc[i] == int'(key_num)) begin
          any_vis = 1;
          if (m_mode[i] == 1) hs = i;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (!playing) begin
        nmode[i] = 0; ncnt[i] = GAPT + i;
      end else if (i == hs) begin
        nmode[i] = 2; ncnt[i] = FLT;
      end else if (m_tick) begin
        if (m_cnt[i] > 1) ncnt[i] = m_cnt[i] - 1;
        else if (m_mode[i] != 0) begin
          nmode[i] = 0; ncnt[i] = GAPT + gseed;
        end else begin
          clash = taken;
          for (int j = 0; j < NS; j++) if (m_mode[j] != 0 && m_loc[j] == cand) clash = 1;
          if (clash) ncnt[i] = 0;
          else begin
            nmode[i] = 1; ncnt[i] = UPT; nloc[i] = cand; taken = 1;
          end
        end
      end
    end
    @(posedge clk);
    m_mode = nmode; m_cnt = ncnt; m_loc = nloc;
    m_a1 = (hs >= 0) && (hs % 3 == 0);
    m_a2 = (hs >= 0) && (hs % 3 == 1);
    m_r2 = (hs >= 0) && (hs % 3 == 2);
    m_miss = MISS_EN && playing && key_valid && !any_vis;
    m_presc = m_tick ? 0 : m_presc + 1;
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (dut_vec !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", dut_vec, 22'd0);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset_idle: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  // No keys: every visible period lasts UPT ticks and no pulse appears.
  task automatic test_idle_run();
    int rise[NS];
    logic [NS-1:0] prev;
    int cyc = 0;
    for (int i = 0; i < NS; i++) rise[i] = -1;
    game_state = 2'b01;
    prev = enable;
    repeat (400) begin
      step();
      cyc++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL idle_run_model: got %h want %h", dut_vec, exp_vec());
      end
      for (int i = 0; i < NS; i++) begin
        if (enable[i] && !prev[i]) rise[i] = cyc;
        if (!enable[i] && prev[i] && rise[i] >= 0) begin
          vectors++;
          if (cyc - rise[i] != UPT * TDIV) begin
            errors++;
            $display("FAIL up_duration slot%0d: got %0d clk want %0d", i, cyc - rise[i], UPT * TDIV);
          end
        end
      end
      prev = enable;
    end
  endtask

  // Wait for a slot to be UP in the model; reports a bounded-wait failure.
  task automatic wait_up(input int slot, input string tag, output bit ok);
    int n = 0;
    ok = 0;
    while (n < 3000) begin
      if (m_mode[slot] == 1 && m_cnt[slot] > 1) begin
        ok = 1;
        break;
      end
      step();
      n++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL %s_wait_model: got %h want %h", tag, dut_vec, exp_vec());
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: slot %0d never up, got enable %b want slot up", tag, slot, enable);
    end
  endtask

  task automatic test_hit();
    bit ok;
    int loc;
    game_state = 2'b01;
    wait_up(1, "hit", ok);
    if (!ok) return;
    loc = m_loc[1];
    key_valid = 1'b1; key_num = 4'(loc);
    step();
    key_valid = 1'b0;
    vectors++;
    if ({add_1, add_2, reduce_2, flag[1]} !== 4'b0101) begin
      errors++;
      $display("FAIL hit_pulse: got a1a2r2flag %b want 0101", {add_1, add_2, reduce_2, flag[1]});
    end
    step();
    vectors++;
    if ({add_1, add_2, reduce_2} !== 3'b000 || flag[1] !== 1'b1) begin
      errors++;
      $display("FAIL hit_pulse_width: got a1a2r2 %b flag %b want 000 1", {add_1, add_2, reduce_2}, flag[1]);
    end
    key_valid = 1'b1; key_num = 4'(loc);
    step();
    key_valid = 1'b0;
    vectors++;
    if ({add_1, add_2, reduce_2} !== 3'b000 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL flash_rehit: got %h want %h", dut_vec, exp_vec());
    end
    repeat (4 * TDIV * FLT) begin
      step();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL flash_decay: got %h want %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int s;
    game_state = 2'b01;
    repeat (3000) begin
      key_valid = ($urandom_range(0, 3) == 0);
      s = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 1) == 1 && m_mode[s] != 0) key_num = 4'(m_loc[s]);
      else key_num = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) begin
        if (game_state == 2'b01) game_state = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
        else game_state = 2'b01;
      end
      step();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_model: got %h want %h", dut_vec, exp_vec());
      end
      for (int i = 0; i < NS; i++) begin
        for (int j = i + 1; j < NS; j++) begin
          if (enable[i] && enable[j]) begin
            vectors++;
            if (location[4*i +: 4] === location[4*j +: 4]) begin
              errors++;
              $display("FAIL distinct_loc %0d/%0d: got %h and %h want different", i, j,
                       location[4*i +: 4], location[4*j +: 4]);
            end
          end
        end
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic test_game_stop();
    bit ok;
    logic [4*NS-1:0] held;
    game_state = 2'b01;
    step();
    wait_up(0, "stop", ok);
    if (!ok) return;
    key_valid = 1'b1; key_num = 4'(m_loc[0]);
    step();
    key_valid = 1'b0;
    vectors++;
    if (flag[0] !== 1'b1 || add_1 !== 1'b1) begin
      errors++;
      $display("FAIL stop_setup: got flag0 %b add_1 %b want 1 1", flag[0], add_1);
    end
    held = location;
    game_state = 2'b10;
    step();
    vectors++;
    if (enable !== '0 || flag !== '0) begin
      errors++;
      $display("FAIL stop_clear: got enable %b flag %b want 0 0", enable, flag);
    end
    repeat (6) begin
      key_valid = 1'b1; key_num = 4'($urandom_range(0, NH - 1));
      step();
      vectors++;
      if ({add_1, add_2, reduce_2} !== 3'b000 || location !== held || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL stop_quiet: got %h want %h loc %h held %h", dut_vec, exp_vec(), location, held);
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    int ticks = 0;
    int n = 0;
    game_state = 2'b01;
    wait_up(2, "areset", ok);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (dut_vec !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", dut_vec, 22'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    while (enable == '0 && n < 200) begin
      step();
      n++;
      if (m_tick) ticks++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL areset_model: got %h want %h", dut_vec, exp_vec());
      end
    end
    vectors++;
    if (enable == '0 || ticks < GAPT) begin
      errors++;
      $display("FAIL respawn_gap: got %0d ticks (enable %b) want >= %0d", ticks, enable, GAPT);
    end
  endtask

`ifdef MOLE_MISS_PENALTY_EN
  task automatic test_miss();
    bit ok;
    game_state = 2'b01;
    wait_up(0, "miss", ok);
    if (!ok) return;
    key_valid = 1'b1; key_num = 4'd15;
    step();
    key_valid = 1'b0;
    vectors++;
    if (dut_miss !== 1'b1 || {add_1, add_2, reduce_2} !== 3'b000) begin
      errors++;
      $display("FAIL miss_pulse: got miss %b pulses %b want 1 000", dut_miss, {add_1, add_2, reduce_2});
    end
    key_valid = 1'b1; key_num = 4'(m_loc[0]);
    step();
    key_valid = 1'b0;
    vectors++;
    if (dut_miss !== 1'b0 || add_1 !== 1'b1) begin
      errors++;
      $display("FAIL miss_on_hit: got miss %b add_1 %b want 0 1", dut_miss, add_1);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_idle_run();
    test_hit();
    test_random();
    test_game_stop();
    test_async_reset();
`ifdef MOLE_MISS_PENALTY_EN
    test_miss();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
